// File: rtl/uart_tx_feeder.sv
// Byte FIFO that drains into a UART transmitter, one frame at a time.
// A new start pulse is issued only once the transmitter is idle with Active and Done both low.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Rst_n,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Data,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  input  logic              i_Clr_Ovf,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic              o_Busy
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_ACT,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t            state;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  logic              drop;
  logic [ADDR_W:0]   count_nxt;

  // Push and drop decisions use the registered full flag, so a pop in the
  // same cycle never frees room for the incoming byte.
  assign push = i_Wr_En && !o_Full;
  assign drop = i_Wr_En && o_Full;
  assign pop  = (state == S_LOAD);

  always_comb begin
    count_nxt = o_Count;
    if (push && !pop)
      count_nxt = o_Count + 1'b1;
    else if (pop && !push)
      count_nxt = o_Count - 1'b1;
  end

  always_ff @(posedge i_Clock) begin
    if (push)
      mem[wr_ptr] <= i_Wr_Data;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Count    <= '0;
      o_Empty    <= 1'b1;
      o_Full     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      o_Count <= count_nxt;
      o_Empty <= (count_nxt == '0);
      o_Full  <= (count_nxt == FULL_CNT);
      if (drop)
        o_Overflow <= 1'b1;
      else if (i_Clr_Ovf)
        o_Overflow <= 1'b0;
    end
  end

  // Drain controller; S_GAP holds off the next byte until Done has fallen,
  // because the transmitter ignores DV during its cleanup cycle.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state     <= S_IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
      o_Busy    <= 1'b0;
    end else begin
      o_Tx_DV <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!o_Empty && !i_Tx_Active && !i_Tx_Done) begin
            state  <= S_LOAD;
            o_Busy <= 1'b1;
          end
        end
        S_LOAD: begin
          o_Tx_Byte <= mem[rd_ptr];
          o_Tx_DV   <= 1'b1;
          state     <= S_START;
        end
        S_START: begin
          state <= S_WAIT_ACT;
        end
        S_WAIT_ACT: begin
          if (i_Tx_Active)
            state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (i_Tx_Done)
            state <= S_GAP;
        end
        S_GAP: begin
          if (!i_Tx_Done) begin
            state  <= S_IDLE;
            o_Busy <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: behavioural UART transmitter and serial receiver around the DUT,
// with expected byte streams kept as queues.
module tb_uart_tx_feeder;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int CPB    = 4;

  logic              i_Clock = 1'b0;
  logic              i_Rst_n;
  logic              i_Wr_En;
  logic [7:0]        i_Wr_Data;
  logic              o_Full;
  logic              o_Empty;
  logic [ADDR_W:0]   o_Count;
  logic              o_Overflow;
  logic              i_Clr_Ovf;
  logic              o_Tx_DV;
  logic [7:0]        o_Tx_Byte;
  logic              o_Busy;
  logic              tb_active;

  // Transmitter model state
  logic              tx_line   = 1'b1;
  logic              tx_active = 1'b0;
  logic              tx_done   = 1'b0;
  logic              hold      = 1'b0;
  int                tphase    = 0;
  int                bitcnt    = 0;
  int                clkcnt    = 0;
  logic [9:0]        frame     = 10'h3FF;

  logic [7:0]        rx_q[$];
  logic [9:0]        last_bits;
  int                dv_pulses = 0;
  int                viol      = 0;
  logic              prev_dv   = 1'b0;

  int                checks    = 0;
  int                failures  = 0;

  assign tb_active = tx_active | hold;

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_Clock     (i_Clock),
    .i_Rst_n     (i_Rst_n),
    .i_Wr_En     (i_Wr_En),
    .i_Wr_Data   (i_Wr_Data),
    .o_Full      (o_Full),
    .o_Empty     (o_Empty),
    .o_Count     (o_Count),
    .o_Overflow  (o_Overflow),
    .i_Clr_Ovf   (i_Clr_Ovf),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Active (tb_active),
    .i_Tx_Done   (tx_done),
    .o_Busy      (o_Busy)
  );

  always #5 i_Clock = ~i_Clock;

  // UART transmitter: start, 8 data LSB first, stop; Done high for 2 cycles; DV ignored in cleanup.
  always @(posedge i_Clock) begin
    case (tphase)
      0: begin
        tx_done <= 1'b0;
        if (o_Tx_DV) begin
          frame     <= {1'b1, o_Tx_Byte, 1'b0};
          bitcnt    <= 0;
          clkcnt    <= 0;
          tx_active <= 1'b1;
          tphase    <= 1;
        end
      end
      1: begin
        tx_line <= frame[bitcnt];
        if (clkcnt == CPB-1) begin
          clkcnt <= 0;
          if (bitcnt == 9) begin
            tphase    <= 2;
            tx_active <= 1'b0;
            tx_done   <= 1'b1;
          end else begin
            bitcnt <= bitcnt + 1;
          end
        end else begin
          clkcnt <= clkcnt + 1;
        end
      end
      default: tphase <= 0;
    endcase
  end

  // Serial receiver sampling mid-bit
  initial begin
    logic [9:0] b;
    forever begin
      @(negedge tx_line);
      repeat (2) @(negedge i_Clock);
      b[0] = tx_line;
      for (int k = 1; k < 10; k++) begin
        repeat (CPB) @(negedge i_Clock);
        b[k] = tx_line;
      end
      last_bits = b;
      rx_q.push_back(b[8:1]);
    end
  end

  // Protocol monitor: DV must be a single-cycle pulse issued only to an idle transmitter
  always @(negedge i_Clock) begin
    if (o_Tx_DV) begin
      dv_pulses <= dv_pulses + 1;
      if (tb_active || tx_done) begin
        viol <= viol + 1;
        $display("FAIL dv_while_busy t=%0t active=%0b done=%0b required both 0", $time, tb_active, tx_done);
      end
      if (prev_dv) begin
        viol <= viol + 1;
        $display("FAIL dv_width t=%0t DV high 2+ cycles, required 1", $time);
      end
    end
    prev_dv <= o_Tx_DV;
  end

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge i_Clock);
      if (!o_Busy && !tx_active && !tx_done && !hold && tphase == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rx_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge i_Clock);
    end
  endtask

  task automatic test_reset();
    i_Rst_n = 1'b0; i_Wr_En = 1'b0; i_Wr_Data = 8'h00; i_Clr_Ovf = 1'b0;
    repeat (3) @(negedge i_Clock);
    checks++;
    if ({o_Empty, o_Full, o_Count, o_Overflow, o_Tx_DV, o_Busy, o_Tx_Byte} !== {1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL reset_state got empty=%0b full=%0b count=%0d ovf=%0b dv=%0b busy=%0b byte=%h required 1 0 0 0 0 0 00",
               o_Empty, o_Full, o_Count, o_Overflow, o_Tx_DV, o_Busy, o_Tx_Byte);
    end
    i_Rst_n = 1'b1;
    repeat (100) @(negedge i_Clock);
    checks++;
    if (dv_pulses !== 0) begin
      failures++;
      $display("FAIL reset_no_dv got %0d DV pulses required 0", dv_pulses);
    end
  endtask

  task automatic test_single_byte();
    bit ok;
    int dvb, done_fall, busy_fall;
    bit seen_done;
    wait_idle(ok);
    rx_q.delete();
    dvb = dv_pulses;
    @(negedge i_Clock); i_Wr_En = 1'b1; i_Wr_Data = 8'hA5;
    @(negedge i_Clock); i_Wr_En = 1'b0;
    checks++;
    if (o_Count !== 5'd1 || o_Tx_DV !== 1'b0) begin
      failures++;
      $display("FAIL single_cycle1 got count=%0d dv=%0b required 1 0", o_Count, o_Tx_DV);
    end
    @(negedge i_Clock);
    checks++;
    if (o_Tx_DV !== 1'b0) begin
      failures++;
      $display("FAIL single_cycle2 got dv=%0b required 0", o_Tx_DV);
    end
    @(negedge i_Clock);
    checks++;
    if (o_Tx_DV !== 1'b1 || o_Tx_Byte !== 8'hA5) begin
      failures++;
      $display("FAIL single_dv_latency got dv=%0b byte=%h at cycle 3, required 1 a5", o_Tx_DV, o_Tx_Byte);
    end
    done_fall = -1; busy_fall = -1; seen_done = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge i_Clock);
      if (tx_done) seen_done = 1'b1;
      if (seen_done && !tx_done && done_fall < 0) done_fall = c;
      if (done_fall >= 0 && !o_Busy) begin
        busy_fall = c;
        break;
      end
    end
    checks++;
    if (done_fall < 0 || busy_fall - done_fall != 1) begin
      failures++;
      $display("FAIL single_busy_fall got done_fall=%0d busy_fall=%0d required busy one cycle after done", done_fall, busy_fall);
    end
    wait_rx(1, 100, ok);
    checks++;
    if (!ok || rx_q[0] !== 8'hA5 || last_bits !== 10'b1101001010) begin
      failures++;
      $display("FAIL single_serial got ok=%0b byte=%h bits=%b required a5 bits=1101001010", ok, ok ? rx_q[0] : 8'h00, last_bits);
    end
    checks++;
    if (o_Count !== 5'd0 || o_Empty !== 1'b1 || dv_pulses - dvb !== 1) begin
      failures++;
      $display("FAIL single_after got count=%0d empty=%0b dvs=%0d required 0 1 1", o_Count, o_Empty, dv_pulses - dvb);
    end
  endtask

  task automatic test_burst();
    bit ok;
    int dvb;
    logic [ADDR_W:0] peak;
    wait_idle(ok);
    rx_q.delete();
    dvb = dv_pulses;
    peak = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_Clock);
      if (o_Count > peak) peak = o_Count;
      i_Wr_En = 1'b1; i_Wr_Data = 8'(i + 1);
    end
    @(negedge i_Clock); i_Wr_En = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (o_Count > peak) peak = o_Count;
      @(negedge i_Clock);
    end
    checks++;
    if (peak !== 5'd4) begin
      failures++;
      $display("FAIL burst_peak got %0d required 4", peak);
    end
    wait_rx(5, 600, ok);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (!ok || rx_q[i] !== 8'(i + 1)) begin
        failures++;
        $display("FAIL burst_byte%0d got %h (ok=%0b) required %h", i, ok ? rx_q[i] : 8'h00, ok, 8'(i + 1));
      end
    end
    repeat (20) @(negedge i_Clock);
    checks++;
    if (dv_pulses - dvb !== 5) begin
      failures++;
      $display("FAIL burst_dv_count got %0d required 5", dv_pulses - dvb);
    end
  endtask

  logic [7:0] fill_exp[$];

  task automatic test_fill_overflow();
    bit ok;
    logic [7:0] d;
    wait_idle(ok);
    rx_q.delete();
    fill_exp.delete();
    hold = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(negedge i_Clock);
      if (k == 16) begin
        checks++;
        if (o_Full !== 1'b1 || o_Count !== 5'd16 || o_Overflow !== 1'b0) begin
          failures++;
          $display("FAIL fill_16 got full=%0b count=%0d ovf=%0b required 1 16 0", o_Full, o_Count, o_Overflow);
        end
      end
      if (k == 17) begin
        checks++;
        if (o_Overflow !== 1'b1) begin
          failures++;
          $display("FAIL fill_ovf17 got ovf=%0b required 1", o_Overflow);
        end
      end
      d = 8'($urandom);
      if (fill_exp.size() < DEPTH) fill_exp.push_back(d);
      i_Wr_En = 1'b1; i_Wr_Data = d;
    end
    @(negedge i_Clock); i_Wr_En = 1'b0;
    checks++;
    if (o_Overflow !== 1'b1 || o_Count !== 5'(fill_exp.size()) || o_Full !== 1'b1) begin
      failures++;
      $display("FAIL fill_18 got ovf=%0b count=%0d full=%0b required 1 %0d 1", o_Overflow, o_Count, o_Full, fill_exp.size());
    end
  endtask

  task automatic test_overflow_clear();
    @(negedge i_Clock); i_Clr_Ovf = 1'b1;
    @(negedge i_Clock); i_Clr_Ovf = 1'b0;
    checks++;
    if (o_Overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got %0b required 0", o_Overflow);
    end
    @(negedge i_Clock); i_Clr_Ovf = 1'b1; i_Wr_En = 1'b1; i_Wr_Data = 8'($urandom);
    @(negedge i_Clock); i_Clr_Ovf = 1'b0; i_Wr_En = 1'b0;
    checks++;
    if (o_Overflow !== 1'b1 || o_Count !== 5'd16) begin
      failures++;
      $display("FAIL ovf_set_priority got ovf=%0b count=%0d required 1 16", o_Overflow, o_Count);
    end
    @(negedge i_Clock); i_Clr_Ovf = 1'b1;
    @(negedge i_Clock); i_Clr_Ovf = 1'b0;
  endtask

  task automatic test_drain_after_fill();
    bit ok;
    hold = 1'b0;
    wait_rx(DEPTH, 1500, ok);
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (!ok || rx_q[i] !== fill_exp[i]) begin
        failures++;
        $display("FAIL drain_byte%0d got %h (ok=%0b) required %h", i, ok ? rx_q[i] : 8'h00, ok, fill_exp[i]);
      end
    end
    repeat (200) @(negedge i_Clock);
    checks++;
    if (rx_q.size() !== DEPTH || o_Empty !== 1'b1 || o_Count !== 5'd0) begin
      failures++;
      $display("FAIL drain_no_extra got rx=%0d empty=%0b count=%0d required %0d 1 0", rx_q.size(), o_Empty, o_Count, DEPTH);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] base;
    logic [7:0] exp_q[$];
    wait_idle(ok);
    rx_q.delete();
    base = 8'($urandom);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge i_Clock);
      @(negedge i_Clock);
      for (int c = 0; c < 300 && o_Full; c++) @(negedge i_Clock);
      i_Wr_En = 1'b1; i_Wr_Data = base + 8'(i);
      exp_q.push_back(base + 8'(i));
      @(negedge i_Clock); i_Wr_En = 1'b0;
    end
    wait_rx(40, 3000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wrap_timeout got %0d bytes required 40", rx_q.size());
    end
    for (int i = 0; i < 40 && ok; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL wrap_byte%0d got %h required %h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (o_Overflow !== 1'b0) begin
      failures++;
      $display("FAIL wrap_ovf got %0b required 0", o_Overflow);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int dvb;
    logic [7:0] exp_q[$];
    logic [7:0] d, nb;
    wait_idle(ok);
    rx_q.delete();
    dvb = dv_pulses;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom);
      if (i < 3) exp_q.push_back(d);
      @(negedge i_Clock); i_Wr_En = 1'b1; i_Wr_Data = d;
    end
    @(negedge i_Clock); i_Wr_En = 1'b0;
    for (int c = 0; c < 600 && dv_pulses - dvb < 3; c++) @(negedge i_Clock);
    repeat (10) @(negedge i_Clock);
    i_Rst_n = 1'b0;
    #1;
    checks++;
    if (o_Tx_DV !== 1'b0 || o_Empty !== 1'b1 || o_Count !== 5'd0 || o_Busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_state got dv=%0b empty=%0b count=%0d busy=%0b required 0 1 0 0", o_Tx_DV, o_Empty, o_Count, o_Busy);
    end
    repeat (2) @(negedge i_Clock);
    i_Rst_n = 1'b1;
    @(negedge i_Clock);
    checks++;
    if (tb_active !== 1'b1) begin
      failures++;
      $display("FAIL midreset_frame3_inflight got active=%0b required 1", tb_active);
    end
    nb = 8'($urandom);
    exp_q.push_back(nb);
    i_Wr_En = 1'b1; i_Wr_Data = nb;
    @(negedge i_Clock); i_Wr_En = 1'b0;
    wait_rx(4, 600, ok);
    repeat (100) @(negedge i_Clock);
    checks++;
    if (!ok || rx_q.size() !== 4) begin
      failures++;
      $display("FAIL midreset_count got %0d frames required 4", rx_q.size());
    end
    for (int i = 0; i < 4 && ok; i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL midreset_byte%0d got %h required %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin
      failures++;
      $display("FAIL protocol_violations got %0d required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_fill_overflow();
    test_overflow_clear();
    test_drain_after_fill();
    test_wrap();
    test_reset_mid_frame();
    test_protocol();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
